// File: rtl/mtimer_unit.sv
// mtimer_unit: memory-mapped RISC-V machine timer (mtime/mtimecmp) with a
// registered mtip level and a tear-free low-then-high mtime read shadow.
`default_nettype none

module mtimer_unit #(
  parameter int PRESCALE = 1,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [31:0]     addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            ack_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            mtip_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

  localparam logic [31:0] ADDR_MTIME_LO    = 32'h0000_8004;
  localparam logic [31:0] ADDR_MTIME_HI    = 32'h0000_8008;
  localparam logic [31:0] ADDR_MTIMECMP_LO = 32'h0000_800C;
  localparam logic [31:0] ADDR_MTIMECMP_HI = 32'h0000_8010;

  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic [31:0]     shadow_hi_q, shadow_hi_d;
  logic            shadow_valid_q, shadow_valid_d;
  logic            ack_q, ack_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mtip_q, mtip_d;

  logic sel_mt_lo, sel_mt_hi, sel_cmp_lo, sel_cmp_hi;
  logic hit, wr, rd, tick;

  always_comb begin
    sel_mt_lo  = req_i && (addr_i == ADDR_MTIME_LO);
    sel_mt_hi  = req_i && (addr_i == ADDR_MTIME_HI);
    sel_cmp_lo = req_i && (addr_i == ADDR_MTIMECMP_LO);
    sel_cmp_hi = req_i && (addr_i == ADDR_MTIMECMP_HI);
    hit        = sel_mt_lo || sel_mt_hi || sel_cmp_lo || sel_cmp_hi;
    wr         = hit && we_i;
    rd         = hit && !we_i;
    tick       = !halt_i && (pcnt_q == PCNT_MAX);

    pcnt_d = pcnt_q;
    if (!halt_i) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    // A software write to either mtime half swallows this cycle's tick.
    mtime_d = mtime_q;
    if (wr && sel_mt_lo) begin
      mtime_d[31:0] = wdata_i;
    end else if (wr && sel_mt_hi) begin
      mtime_d[63:32] = wdata_i;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    mtimecmp_d = mtimecmp_q;
    if (wr && sel_cmp_lo) mtimecmp_d[31:0]  = wdata_i;
    if (wr && sel_cmp_hi) mtimecmp_d[63:32] = wdata_i;

    shadow_hi_d    = shadow_hi_q;
    shadow_valid_d = shadow_valid_q;
    if (rd && sel_mt_lo) begin
      shadow_hi_d    = mtime_q[63:32];
      shadow_valid_d = 1'b1;
    end
    if ((rd && sel_mt_hi) || (wr && (sel_mt_lo || sel_mt_hi))) begin
      shadow_valid_d = 1'b0;
    end

    rdata_d = '0;
    if (rd) begin
      if (sel_mt_lo)       rdata_d = mtime_q[31:0];
      else if (sel_mt_hi)  rdata_d = shadow_valid_q ? shadow_hi_q : mtime_q[63:32];
      else if (sel_cmp_lo) rdata_d = mtimecmp_q[31:0];
      else                 rdata_d = mtimecmp_q[63:32];
    end

    ack_d  = hit;
    mtip_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q         <= '0;
      mtime_q        <= '0;
      mtimecmp_q     <= '1;
      shadow_hi_q    <= '0;
      shadow_valid_q <= 1'b0;
      ack_q          <= 1'b0;
      rdata_q        <= '0;
      mtip_q         <= 1'b0;
    end else begin
      pcnt_q         <= pcnt_d;
      mtime_q        <= mtime_d;
      mtimecmp_q     <= mtimecmp_d;
      shadow_hi_q    <= shadow_hi_d;
      shadow_valid_q <= shadow_valid_d;
      ack_q          <= ack_d;
      rdata_q        <= rdata_d;
      mtip_q         <= mtip_d;
    end
  end

  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign mtip_o  = mtip_q;

endmodule

`default_nettype wire
